// File: rtl/multichannel_layer_if.sv
// rtl/multichannel_layer_if.sv - valid/ready sample streams into and out of multichannel_layer
interface multichannel_layer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_ready;

  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/multichannel_layer.sv
// rtl/multichannel_layer.sv - sums IN_CHANNELS partial maps plus bias, activates and pools them
// LAYER_SAT_EN: saturate (instead of truncate) the pooled result to DATA_WIDTH
module multichannel_layer #(
  parameter int DATA_WIDTH      = 16,
  parameter int MAP_SIZE        = 26,
  parameter int IN_CHANNELS     = 3,
  parameter int POOL_SIZE       = 2,
  parameter int POOL_TYPE       = 1,
  parameter int ACTIVATION_TYPE = 1,
  parameter int ACC_WIDTH       = DATA_WIDTH + $clog2(IN_CHANNELS) + 1
) (
  input  logic                         clk,
  input  logic                         global_rst,
  input  logic                         ce,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         end_op,
  output logic                         busy,
  multichannel_layer_if.slave          s
);
  localparam int NPIX    = MAP_SIZE * MAP_SIZE;
  localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CH_W    = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int OUT_DIM = MAP_SIZE / POOL_SIZE;
  localparam int WIN_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int LOG2P   = $clog2(POOL_SIZE);
  localparam int WP_W    = (POOL_SIZE > 1) ? LOG2P : 1;
  localparam int RED_W   = ACC_WIDTH + 2 * LOG2P;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                        state;
  logic        [PIX_W-1:0]       pix_cnt;
  logic        [CH_W-1:0]        ch_cnt;
  logic signed [DATA_WIDTH-1:0]  bias_q;
  logic        [WIN_W-1:0]       win_r, win_c;
  logic        [WP_W-1:0]        wy, wx;
  logic                          rd_done;
  logic signed [RED_W-1:0]       red_acc;
  logic                          out_valid_q, out_last;
  logic signed [DATA_WIDTH-1:0]  out_data_q;
  logic signed [ACC_WIDTH-1:0]   buf_mem [NPIX];

  logic                          in_xfer, out_xfer, last_pix, last_ch, first_sample;
  logic signed [DATA_WIDTH-1:0]  bias_now;
  logic signed [ACC_WIDTH-1:0]   in_ext, bias_ext, wr_data, word, act;
  logic        [PIX_W-1:0]       rd_addr;
  logic                          win_first, win_last, map_last_win, rd_en, load;
  logic signed [RED_W-1:0]       act_ext, red_next, red_final;
  logic signed [DATA_WIDTH-1:0]  narrowed;

  assign s.in_ready    = ce & global_rst & (state == IDLE || state == ACCUM);
  assign in_xfer       = s.in_valid & s.in_ready;
  assign out_xfer      = ce & out_valid_q & s.out_ready;
  assign s.out_valid   = out_valid_q;
  assign s.out_data    = out_data_q;
  assign end_op        = out_xfer & out_last;
  assign busy          = (state != IDLE);

  assign last_pix      = (pix_cnt == PIX_W'(NPIX - 1));
  assign last_ch       = (ch_cnt == CH_W'(IN_CHANNELS - 1));
  assign first_sample  = (pix_cnt == '0) && (ch_cnt == '0);
  // The very first sample of a map must see the live bias; later channel-0 pixels reuse the sampled copy.
  assign bias_now      = first_sample ? bias : bias_q;
  assign in_ext        = {{(ACC_WIDTH-DATA_WIDTH){s.in_data[DATA_WIDTH-1]}}, s.in_data};
  assign bias_ext      = {{(ACC_WIDTH-DATA_WIDTH){bias_now[DATA_WIDTH-1]}}, bias_now};
  assign wr_data       = (ch_cnt == '0) ? bias_ext + in_ext : buf_mem[pix_cnt] + in_ext;

  always_ff @(posedge clk) begin
    if (in_xfer) buf_mem[pix_cnt] <= wr_data;
  end

  assign rd_addr       = PIX_W'((32'(win_r) * POOL_SIZE + 32'(wy)) * MAP_SIZE
                                + 32'(win_c) * POOL_SIZE + 32'(wx));
  assign word          = buf_mem[rd_addr];
  assign act           = (ACTIVATION_TYPE == 1 && word[ACC_WIDTH-1]) ? '0 : word;
  assign act_ext       = {{(RED_W-ACC_WIDTH){act[ACC_WIDTH-1]}}, act};
  assign win_first     = (wx == '0) && (wy == '0);
  assign win_last      = (wx == WP_W'(POOL_SIZE - 1)) && (wy == WP_W'(POOL_SIZE - 1));
  assign map_last_win  = (win_r == WIN_W'(OUT_DIM - 1)) && (win_c == WIN_W'(OUT_DIM - 1));

  always_comb begin
    red_next = act_ext;
    if (!win_first) begin
      if (POOL_TYPE == 1) red_next = (act_ext > red_acc) ? act_ext : red_acc;
      else                red_next = red_acc + act_ext;
    end
    red_final = (POOL_TYPE == 1) ? red_next : (red_next >>> (2 * LOG2P));
  end

`ifdef LAYER_SAT_EN
  always_comb begin
    narrowed = red_final[DATA_WIDTH-1:0];
    if (!(&red_final[RED_W-1:DATA_WIDTH-1]) && (|red_final[RED_W-1:DATA_WIDTH-1]))
      narrowed = red_final[RED_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  logic unused_high_bits;
  assign narrowed         = red_final[DATA_WIDTH-1:0];
  assign unused_high_bits = ^red_final[RED_W-1:DATA_WIDTH];
`endif

  // A completed window may only land in the output register if that register is free this cycle.
  assign rd_en = ce && (state == DRAIN) && !rd_done && !(win_last && out_valid_q && !s.out_ready);
  assign load  = rd_en && win_last;

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      ch_cnt      <= '0;
      bias_q      <= '0;
      win_r       <= '0;
      win_c       <= '0;
      wy          <= '0;
      wx          <= '0;
      rd_done     <= 1'b0;
      red_acc     <= '0;
      out_valid_q <= 1'b0;
      out_last    <= 1'b0;
      out_data_q  <= '0;
    end else if (ce) begin
      if (in_xfer) begin
        if (first_sample) bias_q <= bias;
        state <= (last_pix && last_ch) ? DRAIN : ACCUM;
        if (last_pix) begin
          pix_cnt <= '0;
          ch_cnt  <= last_ch ? '0 : ch_cnt + CH_W'(1);
        end else begin
          pix_cnt <= pix_cnt + PIX_W'(1);
        end
      end
      if (rd_en) begin
        red_acc <= red_next;
        if (win_last && map_last_win) rd_done <= 1'b1;
        if (wx == WP_W'(POOL_SIZE - 1)) begin
          wx <= '0;
          if (wy == WP_W'(POOL_SIZE - 1)) begin
            wy <= '0;
            if (win_c == WIN_W'(OUT_DIM - 1)) begin
              win_c <= '0;
              win_r <= (win_r == WIN_W'(OUT_DIM - 1)) ? '0 : win_r + WIN_W'(1);
            end else begin
              win_c <= win_c + WIN_W'(1);
            end
          end else begin
            wy <= wy + WP_W'(1);
          end
        end else begin
          wx <= wx + WP_W'(1);
        end
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= narrowed;
        out_last    <= map_last_win;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
      if (out_xfer && out_last) begin
        state   <= IDLE;
        rd_done <= 1'b0;
      end
    end
  end
endmodule
